// File: rtl/nand_pkg.sv
// Shared constants, state encoding and byte-selection helpers for the NAND
// command sequencer.
package nand_pkg;

    localparam int REQ_W     = 3;
    localparam int REQ_READ  = 0;
    localparam int REQ_PROG  = 1;
    localparam int REQ_ERASE = 2;

    localparam logic [7:0] OP_READ1  = 8'h00;
    localparam logic [7:0] OP_READ2  = 8'h30;
    localparam logic [7:0] OP_PROG1  = 8'h80;
    localparam logic [7:0] OP_PROG2  = 8'h10;
    localparam logic [7:0] OP_ERASE1 = 8'h60;
    localparam logic [7:0] OP_ERASE2 = 8'hD0;

    typedef enum logic [2:0] {
        S_IDLE, S_CMD1, S_ADDR, S_DATA, S_CMD2, S_WAIT_TWB, S_WAIT_RB, S_FINISH
    } state_t;

    typedef enum logic [1:0] {CMD_READ, CMD_PROG, CMD_ERASE} cmd_t;

    function automatic logic [7:0] first_opcode(input cmd_t c);
        logic [7:0] op;
        case (c)
            CMD_PROG:  op = OP_PROG1;
            CMD_ERASE: op = OP_ERASE1;
            default:   op = OP_READ1;
        endcase
        return op;
    endfunction

    function automatic logic [7:0] second_opcode(input cmd_t c);
        logic [7:0] op;
        case (c)
            CMD_PROG:  op = OP_PROG2;
            CMD_ERASE: op = OP_ERASE2;
            default:   op = OP_READ2;
        endcase
        return op;
    endfunction

    function automatic logic [2:0] last_addr_idx(input cmd_t c);
        return (c == CMD_ERASE) ? 3'd2 : 3'd4;
    endfunction

    // Erase skips the two column bytes, so its index maps straight onto the row.
    function automatic logic [7:0] addr_byte(input cmd_t c, input logic [2:0] idx,
                                             input logic [15:0] col, input logic [23:0] row);
        logic [7:0] b;
        logic [2:0] ri;
        ri = (c == CMD_ERASE) ? idx : idx - 3'd2;
        if (c != CMD_ERASE && idx < 3'd2)
            b = idx[0] ? col[15:8] : col[7:0];
        else begin
            case (ri)
                3'd0:    b = row[7:0];
                3'd1:    b = row[15:8];
                default: b = row[23:16];
            endcase
        end
        return b;
    endfunction

endpackage

// File: rtl/nand_cmd_sequencer_if.sv
// Host-side request/status bundle of the NAND command sequencer.
interface nand_cmd_sequencer_if;
    import nand_pkg::*;

    logic [REQ_W-1:0] req_pulse;
    logic [15:0]      col_addr;
    logic [23:0]      row_addr;
    logic             data_ack;
    logic             busy;
    logic             data_req;
    logic             done;
    logic             timeout;
    logic             req_err;

    modport master (output req_pulse, col_addr, row_addr, data_ack,
                    input  busy, data_req, done, timeout, req_err);
    modport slave  (input  req_pulse, col_addr, row_addr, data_ack,
                    output busy, data_req, done, timeout, req_err);

endinterface

// File: rtl/nand_bus_cycle.sv
// One WE_n strobe: low for TWP clocks, high for TWH clocks; cycle_done marks
// the last high clock so the next strobe can follow without a gap.
module nand_bus_cycle #(
    parameter int TWP = 2,
    parameter int TWH = 2
) (
    input  logic out_clk,
    input  logic rst,
    input  logic start,
    output logic we_n,
    output logic cycle_done
);

    logic        active;
    logic        low_ph;
    logic [15:0] cnt;

    assign cycle_done = active && !low_ph && (cnt == 16'(TWH - 1));
    assign we_n       = !(active && low_ph);

    always_ff @(posedge out_clk) begin
        if (rst) begin
            active <= 1'b0;
            low_ph <= 1'b0;
            cnt    <= 16'd0;
        end else if (start && (!active || cycle_done)) begin
            active <= 1'b1;
            low_ph <= 1'b1;
            cnt    <= 16'd0;
        end else if (active) begin
            if (low_ph && cnt == 16'(TWP - 1)) begin
                low_ph <= 1'b0;
                cnt    <= 16'd0;
            end else if (cycle_done) begin
                active <= 1'b0;
                cnt    <= 16'd0;
            end else if (cnt != 16'hFFFF) begin
                cnt <= cnt + 16'd1;
            end
        end
    end

endmodule

// File: rtl/nand_cmd_sequencer.sv
// NAND read/program/erase command sequencer: opcode, address bytes, optional
// program data handoff, second opcode, then tWB and ready/busy wait.
module nand_cmd_sequencer
    import nand_pkg::*;
#(
    parameter int TWP  = 2,
    parameter int TWH  = 2,
    parameter int TWB  = 4,
    parameter int TOUT = 65535
) (
    input  logic                 out_clk,
    input  logic                 rst,
    nand_cmd_sequencer_if.slave  host,
    input  logic                 nand_rb_n,
    output logic                 nand_ce_n,
    output logic                 nand_cle,
    output logic                 nand_ale,
    output logic                 nand_we_n,
    output logic [7:0]           nand_dq_out,
    output logic                 nand_dq_oe
);

    state_t      state, state_nxt;
    cmd_t        cmd, req_cmd;
    logic [15:0] col_q;
    logic [23:0] row_q;
    logic [2:0]  byte_idx, byte_nxt;
    logic [15:0] wait_cnt;
    logic [7:0]  dq_q, dq_nxt;
    logic        done_q, tout_q, err_q;
    logic        accept, bc_start, cycle_done, rb_done, rb_tout;

    assign req_cmd = host.req_pulse[REQ_PROG]  ? CMD_PROG  :
                     host.req_pulse[REQ_ERASE] ? CMD_ERASE : CMD_READ;

    nand_bus_cycle #(.TWP(TWP), .TWH(TWH)) u_bus (
        .out_clk    (out_clk),
        .rst        (rst),
        .start      (bc_start),
        .we_n       (nand_we_n),
        .cycle_done (cycle_done)
    );

    // Each bus state launches its strobe in the transition cycle so WE_n
    // falls together with the new byte on the first clock of the state.
    always_comb begin
        state_nxt = state;
        bc_start  = 1'b0;
        dq_nxt    = dq_q;
        byte_nxt  = byte_idx;
        accept    = 1'b0;
        rb_done   = 1'b0;
        rb_tout   = 1'b0;
        case (state)
            S_IDLE: if ($onehot(host.req_pulse)) begin
                accept    = 1'b1;
                state_nxt = S_CMD1;
                bc_start  = 1'b1;
                dq_nxt    = first_opcode(req_cmd);
            end
            S_CMD1: if (cycle_done) begin
                state_nxt = S_ADDR;
                bc_start  = 1'b1;
                byte_nxt  = 3'd0;
                dq_nxt    = addr_byte(cmd, 3'd0, col_q, row_q);
            end
            S_ADDR: if (cycle_done) begin
                if (byte_idx == last_addr_idx(cmd)) begin
                    if (cmd == CMD_PROG) begin
                        state_nxt = S_DATA;
                    end else begin
                        state_nxt = S_CMD2;
                        bc_start  = 1'b1;
                        dq_nxt    = second_opcode(cmd);
                    end
                end else begin
                    byte_nxt = byte_idx + 3'd1;
                    bc_start = 1'b1;
                    dq_nxt   = addr_byte(cmd, byte_idx + 3'd1, col_q, row_q);
                end
            end
            S_DATA: if (host.data_ack) begin
                state_nxt = S_CMD2;
                bc_start  = 1'b1;
                dq_nxt    = second_opcode(cmd);
            end
            S_CMD2:     if (cycle_done) state_nxt = S_WAIT_TWB;
            S_WAIT_TWB: if (wait_cnt == 16'(TWB - 1)) state_nxt = S_WAIT_RB;
            S_WAIT_RB: begin
                if (nand_rb_n) begin
                    state_nxt = S_FINISH;
                    rb_done   = 1'b1;
                end else if (wait_cnt == 16'(TOUT - 1)) begin
                    state_nxt = S_FINISH;
                    rb_tout   = 1'b1;
                end
            end
            S_FINISH: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge out_clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cmd      <= CMD_READ;
            col_q    <= 16'd0;
            row_q    <= 24'd0;
            byte_idx <= 3'd0;
            wait_cnt <= 16'd0;
            dq_q     <= 8'h00;
            done_q   <= 1'b0;
            tout_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_nxt;
            byte_idx <= byte_nxt;
            dq_q     <= dq_nxt;
            done_q   <= rb_done;
            tout_q   <= rb_tout;
            err_q    <= (state != S_IDLE) && (|host.req_pulse);
            if (accept) begin
                cmd   <= req_cmd;
                col_q <= host.col_addr;
                row_q <= host.row_addr;
            end
            if (state_nxt != state)
                wait_cnt <= 16'd0;
            else if (wait_cnt != 16'hFFFF)
                wait_cnt <= wait_cnt + 16'd1;
        end
    end

    assign nand_ce_n     = (state == S_IDLE);
    assign nand_cle      = (state == S_CMD1) || (state == S_CMD2);
    assign nand_ale      = (state == S_ADDR);
    assign nand_dq_oe    = nand_cle || nand_ale;
    assign nand_dq_out   = dq_q;
    assign host.busy     = (state != S_IDLE);
    assign host.data_req = (state == S_DATA);
    assign host.done     = done_q;
    assign host.timeout  = tout_q;
    assign host.req_err  = err_q;

endmodule

// File: doc/nand_cmd_sequencer.md
NAND_CMD_SEQUENCER -- requirements
Module: nand_cmd_sequencer

Interface
REQ-001 Parameters: TWP, default 2, WE_n low width in clocks; TWH, default 2, WE_n high width in clocks; TWB, default 4, clocks after last strobe before sampling nand_rb_n; TOUT, default 65535, R/B busy timeout in clocks.
REQ-002 out_clk  in  1  single block clock, all logic on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 req_pulse  in  3  single-cycle one-hot request from the edge-detect stage; bit0 read, bit1 program, bit2 erase.
REQ-005 col_addr  in  16  column address; row_addr  in  24  row address; both sampled only in the cycle a request is accepted.
REQ-006 data_ack  in  1  program data phase complete, level, held until data_req falls.
REQ-007 nand_rb_n  in  1  NAND ready/busy, 0 = busy, already synchronised.
REQ-008 nand_ce_n, nand_cle, nand_ale, nand_we_n  out  1 each  NAND control pins.
REQ-009 nand_dq_out  out  8  bus byte; nand_dq_oe  out  1  bus drive enable.
REQ-010 busy  out  1  sequence in progress; data_req  out  1  program data phase requested (level).
REQ-011 done  out  1  one-cycle completion pulse; timeout  out  1  one-cycle timeout pulse; req_err  out  1  one-cycle pulse on rejected request.

Function
REQ-012 States: IDLE, CMD1, ADDR, DATA, CMD2, WAIT_TWB, WAIT_RB, FINISH.
REQ-013 IDLE: req_pulse with exactly one bit set latches opcode, col_addr, row_addr; next cycle enters CMD1, busy=1.
REQ-014 req_pulse with zero or multiple bits set in IDLE is ignored; any nonzero req_pulse outside IDLE pulses req_err next cycle and is dropped.
REQ-015 First opcode: read 0x00, program 0x80, erase 0x60; second opcode: read 0x30, program 0x10, erase 0xD0.
REQ-016 ADDR cycles: read/program send col[7:0], col[15:8], row[7:0], row[15:8], row[23:16] (5 cycles); erase sends the 3 row bytes only.
REQ-017 Every bus cycle: nand_dq_out and nand_dq_oe=1 valid for whole cycle; nand_we_n low TWP clocks then high TWH clocks; CLE=1 in CMD1/CMD2, ALE=1 in ADDR, else both 0.
REQ-018 Program only: after ADDR enter DATA, data_req=1, dq_oe=0; on data_ack=1 drop data_req and enter CMD2; DATA has no timeout.
REQ-019 After CMD2: WAIT_TWB for TWB clocks ignoring nand_rb_n, then WAIT_RB.
REQ-020 WAIT_RB: nand_rb_n=1 -> FINISH, done pulses one cycle; counter reaching TOUT -> FINISH, timeout pulses instead of done.
REQ-021 FINISH lasts one cycle, busy=0 on return to IDLE; a request in the FINISH cycle is rejected per REQ-014.
REQ-022 nand_ce_n=0 from CMD1 through FINISH, 1 in IDLE.
REQ-023 Strobe and wait counters 16-bit, saturating, cleared on each state entry.

Reset
REQ-024 rst=1 at any clock edge forces IDLE next cycle, abandoning any sequence with no done/timeout pulse.
REQ-025 Reset values: nand_ce_n=1, nand_we_n=1, nand_cle=0, nand_ale=0, nand_dq_out=0x00, nand_dq_oe=0, busy=0, data_req=0, done=0, timeout=0, req_err=0.

Structure
REQ-026 Package nand_pkg holds opcode constants (0x00, 0x30, 0x80, 0x10, 0x60, 0xD0), state encoding, request bit indices.
REQ-027 Sub-module nand_bus_cycle generates one WE_n strobe (start in, TWP/TWH parameters, cycle_done out); instantiated once.

Verification
REQ-028 Read, col=0x1234, row=0xABCDEF: DQ sequence 0x00,0x34,0x12,0xEF,0xCD,0xAB,0x30; CLE on first/last, ALE on middle five; rb_n low 20 clocks -> one done pulse.
REQ-029 Erase, row=0x000102: DQ 0x60,0x02,0x01,0x00,0xD0; no column bytes; each WE_n low exactly 2 clocks, high 2 clocks.
REQ-030 Program: data_req rises after fifth address byte; data_ack after 10 clocks -> 0x10 issued, done after rb_n rises.
REQ-031 rb_n held low, TOUT=100: timeout pulses once, done never pulses, busy falls.
REQ-032 Request pulse during WAIT_RB: req_err pulses once, running sequence completes unchanged; req_pulse=3'b011 in IDLE: ignored, busy stays 0.
REQ-033 rst asserted during ADDR: next cycle all outputs at REQ-025 values, no done; new read request then completes normally.
